branch_control_unit: RTL and testbench
======================================

BRANCH_CONTROL_UNIT -- requirements
Module: branch_control_unit

Interface
REQ-001 Single clock `clock`; reset `clear` is synchronous and active-high; all state updates occur on the rising edge of `clock`.
REQ-002 clock  input  1  system clock.
REQ-003 clear  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to fetch and execute one instruction; sampled only in IDLE or DONE.
REQ-005 ir_in  input  32  IR register contents from datapath; opcode = ir_in[31:27].
REQ-006 con_in  input  1  CON_FF output from datapath (branch condition met).
REQ-007 incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR  output  1 each  datapath register enables.
REQ-008 e_CON_FF, ram_read, MDR_read  output  1 each  condition-FF load, RAM read, MDR memory select.
REQ-009 Gra, e_Rout, imm_sel  output  1 each  select Ra field, register-file drive, C-sign-extended immediate select.
REQ-010 ALU_op  output  4  ALU operation (0011 = ADD, else 0000).
REQ-011 BusDataSelect  output  5  bus source; PCout 10100, Zlowout 10011, MDRout 10101, Cout 01100, none 00000.
REQ-012 busy  output  1  high in every state except IDLE, DONE and FAULT.
REQ-013 done  output  1  one-cycle pulse when an instruction completes.
REQ-014 illegal  output  1  sticky: non-branch opcode decoded.
REQ-015 instr_count  output  8  completed-instruction counter.

Function
REQ-016 The FSM SHALL have states IDLE, F0, F1, F2, F3, DEC, C3, C4, C5, C6, DONE, FAULT; outputs are Moore (decoded from state only, except e_PC in C6); unlisted outputs are 0.
REQ-017 IDLE: all outputs 0; start=1 -> F0, else stay.
REQ-018 F0: BusDataSelect=PCout, e_MAR=1, incPC=1, e_Z=1; -> F1.
REQ-019 F1: ram_read=1, BusDataSelect=Zlowout; -> F2.
REQ-020 F2: MDR_read=1, e_MDR=1; -> F3.
REQ-021 F3: BusDataSelect=MDRout, e_IR=1; -> DEC.
REQ-022 DEC: no outputs; ir_in[31:27]==01001 -> C3, else -> FAULT.
REQ-023 C3: Gra=1, e_Rout=1, e_CON_FF=1; -> C4.
REQ-024 C4: BusDataSelect=PCout, e_Y=1; -> C5.
REQ-025 C5: BusDataSelect=Cout, imm_sel=1, ALU_op=0011, e_Z=1; -> C6.
REQ-026 C6: BusDataSelect=Zlowout, e_PC=con_in; -> DONE.
REQ-027 DONE: done=1, instr_count increments by 1 (255 wraps to 0); start=1 -> F0 (back-to-back, no IDLE), else -> IDLE.
REQ-028 FAULT: illegal=1, all other outputs 0 (busy=0); start ignored; exit only via clear.
REQ-029 start is ignored in all states other than IDLE and DONE.
REQ-030 Latency: start sampled at edge k -> done high during the 10th cycle after k (taken or not taken, macro undefined).

Reset
REQ-031 clear=1 at any edge, including mid-instruction, forces IDLE, instr_count=0, illegal=0, and all outputs 0 from the next cycle; clear takes priority over start.

Configuration
REQ-032 BR_NOT_TAKEN_SKIP_EN defined: in C4, if con_in=0, all C4 outputs are suppressed and next state is DONE (done in cycle 8); undefined: C4-C6 always execute and only e_PC is gated by con_in.

Verification
REQ-033 clear, then start pulse, ir_in=0x48B00000, con_in=1 -> per-cycle outputs exactly as REQ-018..026, e_PC=1 in cycle 9, done in cycle 10, instr_count=1.
REQ-034 Same stimulus with con_in=0, macro undefined -> e_PC=0 in every cycle, done in cycle 10; macro defined -> C4 outputs zero, done in cycle 8.
REQ-035 ir_in=0x08000000 -> illegal=1 from cycle 6 onward, busy=0; a later start pulse produces no output activity until clear.
REQ-036 clear asserted during C5 -> next cycle all outputs 0, state IDLE, instr_count=0.
REQ-037 start held high for 256 instructions -> DONE goes directly to F0 each time, instr_count reads 0 after the 256th done, and no IDLE cycles occur.

Source files
------------

// File: rtl/branch_control_unit_if.sv
// Control/datapath signal bundle for branch_control_unit: instruction-side
// inputs plus every datapath enable, bus select and status output.
interface branch_control_unit_if;
  logic        start;
  logic [31:0] ir_in;
  logic        con_in;
  logic        incPC;
  logic        e_PC;
  logic        e_IR;
  logic        e_Y;
  logic        e_Z;
  logic        e_MAR;
  logic        e_MDR;
  logic        e_CON_FF;
  logic        ram_read;
  logic        MDR_read;
  logic        Gra;
  logic        e_Rout;
  logic        imm_sel;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [7:0]  instr_count;

  modport master (
    output start, ir_in, con_in,
    input  incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, e_CON_FF, ram_read, MDR_read,
    input  Gra, e_Rout, imm_sel, ALU_op, BusDataSelect, busy, done, illegal, instr_count
  );

  modport slave (
    input  start, ir_in, con_in,
    output incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, e_CON_FF, ram_read, MDR_read,
    output Gra, e_Rout, imm_sel, ALU_op, BusDataSelect, busy, done, illegal, instr_count
  );
endinterface

// File: rtl/branch_control_unit.sv
// Fetch/decode/execute sequencer for conditional branch instructions (opcode 01001).
// Optional BR_NOT_TAKEN_SKIP_EN: a not-taken branch skips C4..C6 and completes early.
module branch_control_unit (
  input logic                 clock,
  input logic                 clear,
  branch_control_unit_if.slave bus
);
  localparam logic [4:0] BUS_NONE = 5'b00000;
  localparam logic [4:0] BUS_PC   = 5'b10100;
  localparam logic [4:0] BUS_ZLO  = 5'b10011;
  localparam logic [4:0] BUS_MDR  = 5'b10101;
  localparam logic [4:0] BUS_C    = 5'b01100;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [4:0] OP_BR    = 5'b01001;

  typedef enum logic [3:0] {
    IDLE, F0, F1, F2, F3, DEC, C3, C4, C5, C6, DONE, FAULT
  } state_t;

  typedef struct packed {
    logic       inc_pc;
    logic       e_ir;
    logic       e_y;
    logic       e_z;
    logic       e_mar;
    logic       e_mdr;
    logic       e_con_ff;
    logic       ram_read;
    logic       mdr_read;
    logic       gra;
    logic       e_rout;
    logic       imm_sel;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [3:0] alu_op;
    logic [4:0] bus_sel;
  } ctrl_t;

  state_t      state;
  state_t      state_nxt;
  ctrl_t       ctrl;
  logic [7:0]  count;
  logic        skip_c4;
  logic        unused_ir_bits;

  assign unused_ir_bits = ^bus.ir_in[26:0];

`ifdef BR_NOT_TAKEN_SKIP_EN
  assign skip_c4 = (state == C4) && !bus.con_in;
`else
  assign skip_c4 = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = F0;
      F0:      state_nxt = F1;
      F1:      state_nxt = F2;
      F2:      state_nxt = F3;
      F3:      state_nxt = DEC;
      DEC:     state_nxt = (bus.ir_in[31:27] == OP_BR) ? C3 : FAULT;
      C3:      state_nxt = C4;
      C4:      state_nxt = skip_c4 ? DONE : C5;
      C5:      state_nxt = C6;
      C6:      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? F0 : IDLE;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered by decoding the state being entered.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      F0:    begin c.bus_sel = BUS_PC;  c.e_mar = 1'b1; c.inc_pc = 1'b1; c.e_z = 1'b1; end
      F1:    begin c.bus_sel = BUS_ZLO; c.ram_read = 1'b1; end
      F2:    begin c.mdr_read = 1'b1; c.e_mdr = 1'b1; end
      F3:    begin c.bus_sel = BUS_MDR; c.e_ir = 1'b1; end
      C3:    begin c.gra = 1'b1; c.e_rout = 1'b1; c.e_con_ff = 1'b1; end
      C4:    begin c.bus_sel = BUS_PC;  c.e_y = 1'b1; end
      C5:    begin c.bus_sel = BUS_C;   c.imm_sel = 1'b1; c.alu_op = ALU_ADD; c.e_z = 1'b1; end
      C6:    c.bus_sel = BUS_ZLO;
      DONE:  c.done = 1'b1;
      FAULT: c.illegal = 1'b1;
      default: c = '0;
    endcase
    c.busy = !(s inside {IDLE, DONE, FAULT});
    return c;
  endfunction

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      ctrl  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= decode(state_nxt);
      if (state == DONE) count <= count + 8'd1;
    end
  end

  // e_PC follows con_in live during C6; C4 drive is masked live when skipping.
  assign bus.e_PC          = (state == C6) && bus.con_in;
  assign bus.e_Y           = ctrl.e_y && !skip_c4;
  assign bus.BusDataSelect = skip_c4 ? BUS_NONE : ctrl.bus_sel;
  assign bus.incPC         = ctrl.inc_pc;
  assign bus.e_IR          = ctrl.e_ir;
  assign bus.e_Z           = ctrl.e_z;
  assign bus.e_MAR         = ctrl.e_mar;
  assign bus.e_MDR         = ctrl.e_mdr;
  assign bus.e_CON_FF      = ctrl.e_con_ff;
  assign bus.ram_read      = ctrl.ram_read;
  assign bus.MDR_read      = ctrl.mdr_read;
  assign bus.Gra           = ctrl.gra;
  assign bus.e_Rout        = ctrl.e_rout;
  assign bus.imm_sel       = ctrl.imm_sel;
  assign bus.ALU_op        = ctrl.alu_op;
  assign bus.busy          = ctrl.busy;
  assign bus.done          = ctrl.done;
  assign bus.illegal       = ctrl.illegal;
  assign bus.instr_count   = count;
endmodule

// File: tb/tb_branch_control_unit.sv
// Self-checking bench for branch_control_unit: per-cycle table of the taken-branch
// sequence, directed corner cases, and randomized traffic against a cycle-index model.
module tb_branch_control_unit;
  logic clock;
  logic clear;
  branch_control_unit_if bus ();

  branch_control_unit dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, e_CON_FF;
    logic       ram_read, MDR_read, Gra, e_Rout, imm_sel, busy, done, illegal;
    logic [3:0] alu;
    logic [4:0] bsel;
  } out_t;

  localparam logic [31:0] IR_BR  = 32'h48B0_0000;
  localparam logic [31:0] IR_BAD = 32'h0800_0000;

  out_t        tbl [10];
  int          checks;
  int          errors;
  int          phase;      // 0 = idle, 1..10 = cycle number within an instruction
  bit          faulted;
  int unsigned mcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.incPC = bus.incPC;       o.e_PC = bus.e_PC;         o.e_IR = bus.e_IR;
    o.e_Y = bus.e_Y;           o.e_Z = bus.e_Z;           o.e_MAR = bus.e_MAR;
    o.e_MDR = bus.e_MDR;       o.e_CON_FF = bus.e_CON_FF; o.ram_read = bus.ram_read;
    o.MDR_read = bus.MDR_read; o.Gra = bus.Gra;           o.e_Rout = bus.e_Rout;
    o.imm_sel = bus.imm_sel;   o.busy = bus.busy;         o.done = bus.done;
    o.illegal = bus.illegal;   o.alu = bus.ALU_op;        o.bsel = bus.BusDataSelect;
    return o;
  endfunction

  function automatic out_t expect_out(input int ph, input bit flt, input bit con);
    out_t e;
    e = '0;
    if (flt) begin
      e.illegal = 1'b1;
      return e;
    end
    if (ph == 0) return e;
    e = tbl[ph-1];
    if (ph == 9) e.e_PC = con;
`ifdef BR_NOT_TAKEN_SKIP_EN
    if (ph == 7 && !con) begin
      e.e_Y  = 1'b0;
      e.bsel = 5'b00000;
    end
`endif
    return e;
  endfunction

  task automatic model_step(input bit s, input logic [31:0] ir, input bit con, input bit clr);
    if (clr) begin
      phase = 0; faulted = 1'b0; mcount = 0;
    end else if (!faulted) begin
      if (phase == 0) phase = s ? 1 : 0;
      else if (phase == 10) begin
        mcount = (mcount + 1) % 256;
        phase  = s ? 1 : 0;
      end else if (phase == 5) begin
        if (ir[31:27] == 5'b01001) phase = 6;
        else begin
          faulted = 1'b1; phase = 0;
        end
      end
`ifdef BR_NOT_TAKEN_SKIP_EN
      else if (phase == 7 && !con) phase = 10;
`endif
      else phase = phase + 1;
    end
  endtask

  // One clock: apply inputs, advance, update model, compare every output.
  task automatic tick(input bit s, input logic [31:0] ir, input bit con, input bit clr);
    bus.start = s; bus.ir_in = ir; bus.con_in = con; clear = clr;
    @(posedge clock);
    model_step(s, ir, con, clr);
    #1;
    chk("outputs", 32'(sample()), 32'(expect_out(phase, faulted, con)));
    chk("instr_count", 32'(bus.instr_count), mcount);
    if (phase == 9 && !faulted) begin
      bus.con_in = !con;
      #1;
      chk("e_PC_live", 32'(bus.e_PC), 32'(!con));
      bus.con_in = con;
      #1;
    end
  endtask

  initial begin
    int n;
    int dones;
    int idles;
    logic [31:0] ir;
    checks = 0; errors = 0; phase = 0; faulted = 1'b0; mcount = 0;

    for (int unsigned i = 0; i < 10; i++) tbl[i] = '0;
    tbl[0].bsel = 5'b10100; tbl[0].e_MAR = 1'b1; tbl[0].incPC = 1'b1; tbl[0].e_Z = 1'b1;
    tbl[1].ram_read = 1'b1; tbl[1].bsel = 5'b10011;
    tbl[2].MDR_read = 1'b1; tbl[2].e_MDR = 1'b1;
    tbl[3].bsel = 5'b10101; tbl[3].e_IR = 1'b1;
    tbl[5].Gra = 1'b1; tbl[5].e_Rout = 1'b1; tbl[5].e_CON_FF = 1'b1;
    tbl[6].bsel = 5'b10100; tbl[6].e_Y = 1'b1;
    tbl[7].bsel = 5'b01100; tbl[7].imm_sel = 1'b1; tbl[7].alu = 4'b0011; tbl[7].e_Z = 1'b1;
    tbl[8].bsel = 5'b10011; tbl[8].e_PC = 1'b1;
    tbl[9].done = 1'b1;
    for (int unsigned i = 0; i < 9; i++) tbl[i].busy = 1'b1;

    // Reset state
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("reset_outputs", 32'(sample()), 32'h0);
    chk("reset_count", 32'(bus.instr_count), 32'h0);

    // Taken branch, cycle by cycle against the table
    tick(1'b1, IR_BR, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("taken_cycle%0d", c), 32'(sample()), 32'(tbl[c-1]));
      tick(1'b0, IR_BR, 1'b1, 1'b0);
    end
    chk("taken_count", 32'(bus.instr_count), 32'd1);

    // Not-taken branch: latency and e_PC never asserted
    tick(1'b1, IR_BR, 1'b0, 1'b0);
    n = 1;
    idles = 0;
    while (!bus.done && n < 20) begin
      if (bus.e_PC) idles++;
      tick(1'b0, IR_BR, 1'b0, 1'b0);
      n++;
    end
`ifdef BR_NOT_TAKEN_SKIP_EN
    chk("not_taken_latency", n, 8);
`else
    chk("not_taken_latency", n, 10);
`endif
    chk("not_taken_no_e_PC", idles, 0);
    tick(1'b0, IR_BR, 1'b0, 1'b0);
    chk("not_taken_count", 32'(bus.instr_count), 32'd2);

    // Illegal opcode: sticky fault, start ignored, only clear exits
    tick(1'b1, IR_BAD, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, IR_BAD, 1'b0, 1'b0);
    chk("illegal_cycle6", 32'(bus.illegal), 32'd1);
    chk("illegal_busy", 32'(bus.busy), 32'd0);
    tick(1'b1, IR_BR, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, IR_BR, 1'b1, 1'b0);
    chk("fault_held", 32'(bus.illegal), 32'd1);
    tick(1'b0, IR_BR, 1'b0, 1'b1);
    chk("fault_cleared", 32'(sample()), 32'h0);

    // Clear during C5 after one completed instruction
    tick(1'b1, IR_BR, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, IR_BR, 1'b1, 1'b0);
    chk("pre_clear_count", 32'(bus.instr_count), 32'd1);
    tick(1'b1, IR_BR, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b0, IR_BR, 1'b1, 1'b0);
    chk("in_C5", 32'(bus.ALU_op), 32'h3);
    tick(1'b1, IR_BR, 1'b1, 1'b1);
    chk("clear_C5_outputs", 32'(sample()), 32'h0);
    chk("clear_C5_count", 32'(bus.instr_count), 32'd0);
    tick(1'b0, IR_BR, 1'b1, 1'b0);

    // 256 back-to-back instructions with start held high
    dones = 0;
    idles = 0;
    tick(1'b1, IR_BR, 1'b1, 1'b0);
    for (int c = 1; c <= 2560; c++) begin
      if (bus.done) dones++;
      if (!bus.busy && !bus.done) idles++;
      tick(c < 2560, IR_BR, 1'($urandom_range(1)), 1'b0);
    end
`ifdef BR_NOT_TAKEN_SKIP_EN
    chk("b2b_dones_min", 32'(dones >= 256), 32'd1);
`else
    chk("b2b_dones", dones, 256);
`endif
    chk("b2b_no_idle", idles, 0);

    // Randomized traffic
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) != 0) ir = {5'b01001, 27'($urandom)};
      else ir = {5'($urandom_range(31)), 27'($urandom)};
      tick($urandom_range(2) == 0, ir, 1'($urandom_range(1)), $urandom_range(39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
